// File: rtl/uart_cfg.sv
// UART with a runtime baud divisor, configurable frame format and FWFT TX/RX FIFOs.
// TX and RX FSMs share one state encoding:
//   state   | meaning
//   S_IDLE  | line idle, waiting for a queued byte (TX) or a low level (RX)
//   S_START | start bit
//   S_DATA  | data bits, LSB first
//   S_PAR   | parity bit (unused when PARITY=0)
//   S_STOP  | stop bit(s); RX leaves at the mid-stop sample

module uart_cfg_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk)
      if (push) mem[wptr] <= wdata;
endmodule

module uart_cfg #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16,
   localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic                 rxd,
   output logic                 txd,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   input  logic                 err_clr,
   output logic                 tx_busy,
   output logic [CW-1:0]        tx_count,
   output logic [CW-1:0]        rx_count
);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);
   localparam logic [5:0] TX_STOP_END = 6'(STOP_BITS * 16 - 1);
   localparam logic       PAR_ODD     = (PARITY == 2);
   localparam bit         HAS_PAR     = (PARITY != 0);

   // baud generator; >= lets a shrunk divisor wrap on the next cycle
   logic [DIV_W-1:0] baud_cnt;
   logic             tick16;

   assign tick16 = (baud_cnt >= baud_div);

   always_ff @(posedge clk)
      if (rst || tick16) baud_cnt <= '0;
      else               baud_cnt <= baud_cnt + 1'b1;

   state_t               tx_state, tx_next;
   logic [5:0]           tx_tcnt;
   logic [2:0]           tx_bit;
   logic [DATA_BITS-1:0] tx_sh, tx_head;
   logic                 tx_par, tx_empty, tx_full, tx_pop, tx_bit_end;

   uart_cfg_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk, .rst, .push(tx_valid && tx_ready), .wdata(tx_data), .pop(tx_pop),
      .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count));

   assign tx_ready   = !tx_full;
   assign tx_bit_end = tick16 && (tx_tcnt == ((tx_state == S_STOP) ? TX_STOP_END : 6'd15));

   always_ff @(posedge clk)
      if (rst) tx_state <= S_IDLE;
      else     tx_state <= tx_next;

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      case (tx_state)
         S_IDLE:  if (tick16 && !tx_empty) begin tx_next = S_START; tx_pop = 1'b1; end
         S_START: if (tx_bit_end) tx_next = S_DATA;
         S_DATA:  if (tx_bit_end && tx_bit == LAST_BIT) tx_next = HAS_PAR ? S_PAR : S_STOP;
         S_PAR:   if (tx_bit_end) tx_next = S_STOP;
         S_STOP:  if (tx_bit_end) begin
                     if (!tx_empty) begin tx_next = S_START; tx_pop = 1'b1; end
                     else tx_next = S_IDLE;
                  end
         default: tx_next = S_IDLE;
      endcase
   end

   always_comb begin
      txd = 1'b1;
      case (tx_state)
         S_START: txd = 1'b0;
         S_DATA:  txd = tx_sh[0];
         S_PAR:   txd = tx_par;
         default: txd = 1'b1;
      endcase
   end

   assign tx_busy = (tx_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_tcnt <= '0;
         tx_bit  <= '0;
         tx_sh   <= '0;
         tx_par  <= 1'b0;
      end else begin
         if (tx_pop) begin
            tx_sh  <= tx_head;
            tx_par <= (^tx_head) ^ PAR_ODD;
            tx_bit <= '0;
         end else if (tx_state == S_DATA && tx_bit_end) begin
            tx_sh  <= tx_sh >> 1;
            tx_bit <= tx_bit + 1'b1;
         end
         if (tick16) tx_tcnt <= (tx_bit_end || tx_state == S_IDLE) ? '0 : tx_tcnt + 1'b1;
      end
   end

   logic                 rxd_m, rxd_s;
   state_t               rx_state, rx_next;
   logic [3:0]           rx_tcnt;
   logic [2:0]           rx_bit;
   logic [DATA_BITS-1:0] rx_sh;
   logic                 rx_perr, rx_sample, rx_push, rx_wr, rx_pop, rx_full, rx_empty;
   logic [DATA_BITS+1:0] rx_head;

   always_ff @(posedge clk)
      if (rst) {rxd_m, rxd_s} <= 2'b11;
      else     {rxd_m, rxd_s} <= {rxd, rxd_m};

   // START resamples mid-bit after 8 ticks; later bits every 16 ticks from there
   assign rx_sample = tick16 && (rx_tcnt == ((rx_state == S_START) ? 4'd7 : 4'd15));

   always_ff @(posedge clk)
      if (rst) rx_state <= S_IDLE;
      else     rx_state <= rx_next;

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE:  if (tick16 && !rxd_s) rx_next = S_START;
         S_START: if (rx_sample) rx_next = rxd_s ? S_IDLE : S_DATA;
         S_DATA:  if (rx_sample && rx_bit == LAST_BIT) rx_next = HAS_PAR ? S_PAR : S_STOP;
         S_PAR:   if (rx_sample) rx_next = S_STOP;
         S_STOP:  if (rx_sample) rx_next = S_IDLE;
         default: rx_next = S_IDLE;
      endcase
   end

   always_comb begin
      rx_push = (rx_state == S_STOP) && rx_sample;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_tcnt <= '0;
         rx_bit  <= '0;
         rx_sh   <= '0;
         rx_perr <= 1'b0;
      end else begin
         if (tick16) rx_tcnt <= (rx_sample || rx_state == S_IDLE) ? '0 : rx_tcnt + 1'b1;
         if (rx_state == S_IDLE) begin
            rx_bit  <= '0;
            rx_perr <= 1'b0;
         end
         if (rx_sample && rx_state == S_DATA) begin
            rx_sh  <= {rxd_s, rx_sh[DATA_BITS-1:1]};
            rx_bit <= rx_bit + 1'b1;
         end
         if (rx_sample && rx_state == S_PAR) rx_perr <= rxd_s ^ (^rx_sh) ^ PAR_ODD;
      end
   end

   // a pop in the same cycle frees the slot, so a full FIFO can still take the byte
   assign rx_pop = rx_valid && rx_ready;
   assign rx_wr  = rx_push && (!rx_full || rx_pop);

   uart_cfg_fifo #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk, .rst, .push(rx_wr), .wdata({rx_perr, !rxd_s, rx_sh}), .pop(rx_pop),
      .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count));

   assign rx_valid      = !rx_empty;
   assign rx_data       = rx_valid ? rx_head[DATA_BITS-1:0] : '0;
   assign rx_frame_err  = rx_valid && rx_head[DATA_BITS];
   assign rx_parity_err = rx_valid && rx_head[DATA_BITS+1];

   always_ff @(posedge clk)
      if (rst) rx_overrun <= 1'b0;
      else     rx_overrun <= (rx_push && rx_full && !rx_pop) || (rx_overrun && !err_clr);
endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: an 8N1 instance and a 7-bit even-parity, 2-stop instance.
`timescale 1ns/1ps
module tb_uart_cfg;
   localparam int DEPTH = 4;

   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   logic [15:0] baud_a = 16'd3, baud_b = 16'd3;
   logic loop_a = 1'b0, drv_a = 1'b1, loop_b = 1'b0, drv_b = 1'b1;
   logic rxd_a, txd_a, tx_valid_a = 1'b0, tx_ready_a, rx_valid_a, rx_ready_a = 1'b0;
   logic perr_a, ferr_a, ovr_a, err_clr_a = 1'b0, busy_a;
   logic [7:0] tx_data_a = '0, rx_data_a;
   logic [2:0] tx_cnt_a, rx_cnt_a;
   logic rxd_b, txd_b, tx_valid_b = 1'b0, tx_ready_b, rx_valid_b, rx_ready_b = 1'b0;
   logic perr_b, ferr_b, ovr_b, err_clr_b = 1'b0, busy_b;
   logic [6:0] tx_data_b = '0, rx_data_b;
   logic [2:0] tx_cnt_b, rx_cnt_b;

   logic [9:0] q_a[$], q_b[$];

   assign rxd_a = loop_a ? txd_a : drv_a;
   assign rxd_b = loop_b ? txd_b : drv_b;

   uart_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .DIV_W(16)) u_a (
      .clk(clk), .rst(rst), .baud_div(baud_a), .rxd(rxd_a), .txd(txd_a),
      .tx_valid(tx_valid_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
      .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_ready(rx_ready_a),
      .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_overrun(ovr_a), .err_clr(err_clr_a),
      .tx_busy(busy_a), .tx_count(tx_cnt_a), .rx_count(rx_cnt_a));

   uart_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .DIV_W(16)) u_b (
      .clk(clk), .rst(rst), .baud_div(baud_b), .rxd(rxd_b), .txd(txd_b),
      .tx_valid(tx_valid_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
      .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_ready(rx_ready_b),
      .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_overrun(ovr_b), .err_clr(err_clr_b),
      .tx_busy(busy_b), .tx_count(tx_cnt_b), .rx_count(rx_cnt_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // line frames, bit 0 first: start, data, [parity], stop(s)
   function automatic logic [15:0] frame_a(input logic [7:0] d, input logic stop);
      return {6'b0, stop, d, 1'b0};
   endfunction

   function automatic logic [15:0] frame_b(input logic [6:0] d, input logic flip, input logic stop);
      return {5'b0, 1'b1, stop, (^d) ^ flip, d, 1'b0};
   endfunction

   // one bit = 16 ticks x 4 clk at baud_div 3
   task automatic bang(input bit sel, input logic [15:0] bits, input int nb);
      for (int i = 0; i < nb; i++) begin
         if (sel) drv_b = bits[i]; else drv_a = bits[i];
         repeat (64) @(negedge clk);
      end
      drv_a = 1'b1;
      drv_b = 1'b1;
      repeat (128) @(negedge clk);
   endtask

   task automatic wait_rx(input bit sel, input int n, input string tag);
      int t = 0;
      while (int'(sel ? rx_cnt_b : rx_cnt_a) < n && t < 4000) begin
         @(negedge clk);
         t++;
      end
      chk(tag, sel ? rx_cnt_b : rx_cnt_a, n);
   endtask

   task automatic drain(input bit sel, input int n);
      logic [9:0] obs, exp;
      for (int i = 0; i < n; i++) begin
         obs = sel ? {perr_b, ferr_b, 1'b0, rx_data_b} : {perr_a, ferr_a, rx_data_a};
         exp = 'x;
         if (sel && q_b.size() > 0)       exp = q_b.pop_front();
         else if (!sel && q_a.size() > 0) exp = q_a.pop_front();
         chk(sel ? "rx_valid_b" : "rx_valid_a", sel ? rx_valid_b : rx_valid_a, 1);
         chk(sel ? "rx_word_b" : "rx_word_a", obs, exp);
         if (sel) rx_ready_b = 1'b1; else rx_ready_a = 1'b1;
         @(negedge clk);
         rx_ready_a = 1'b0;
         rx_ready_b = 1'b0;
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, low_cnt, run, high_cnt, acc, t;
      bit run_done;
      logic par_s, nxt_s;

      repeat (4) @(negedge clk);
      chk("rst_txd", txd_a, 1);
      chk("rst_tx_ready", tx_ready_a, 1);
      chk("rst_tx_busy", busy_a, 0);
      chk("rst_rx_valid", rx_valid_a, 0);
      chk("rst_rx_data", rx_data_a, 0);
      chk("rst_flags", {perr_a, ferr_a, ovr_a}, 0);
      chk("rst_counts", {tx_cnt_a, rx_cnt_a}, 0);
      chk("rst_txd_b", txd_b, 1);
      rst = 1'b0;

      // 8N1 loopback: 0xA5 then 0x3C, back to back
      loop_a = 1'b1;
      @(negedge clk);
      tx_valid_a = 1'b1; tx_data_a = 8'hA5;
      q_a.push_back({2'b00, 8'hA5});
      @(negedge clk);
      tx_valid_a = 1'b0;
      lat = 0;
      while (txd_a !== 1'b0 && lat < 70) begin
         @(negedge clk);
         lat++;
      end
      chk("tx_latency_ok", (lat >= 1 && lat <= 5), 1);
      low_cnt = 0; run = 0; run_done = 0;
      for (int k = 0; k < 640; k++) begin
         if (k == 10) begin
            tx_valid_a = 1'b1; tx_data_a = 8'h3C;
            q_a.push_back({2'b00, 8'h3C});
         end
         if (k == 11) tx_valid_a = 1'b0;
         if (txd_a == 1'b0) low_cnt++;
         if (!run_done) begin
            if (txd_a == 1'b0) run++; else run_done = 1;
         end
         @(negedge clk);
      end
      chk("tx_start_run", run, 64);
      chk("tx_frame_low", low_cnt, 320);
      chk("tx_no_gap", txd_a, 0);
      wait_rx(0, 2, "rx_a_two");
      drain(0, 2);

      // 7E2 TX: parity bit on line and 32 stop ticks between frames
      loop_b = 1'b1;
      tx_valid_b = 1'b1; tx_data_b = 7'h07;
      q_b.push_back({3'b000, 7'h07});
      @(negedge clk);
      tx_valid_b = 1'b0;
      t = 0;
      while (txd_b !== 1'b0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("b_start", txd_b, 0);
      high_cnt = 0; par_s = 1'bx; nxt_s = 1'bx;
      for (int k = 0; k < 705; k++) begin
         if (k == 10) begin
            tx_valid_b = 1'b1; tx_data_b = 7'h55;
            q_b.push_back({3'b000, 7'h55});
         end
         if (k == 11) tx_valid_b = 1'b0;
         if (k == 544) par_s = txd_b;
         if (k >= 576 && k < 704 && txd_b == 1'b1) high_cnt++;
         if (k == 704) nxt_s = txd_b;
         @(negedge clk);
      end
      chk("b_parity_bit", par_s, 1);
      chk("b_stop_high", high_cnt, 128);
      chk("b_next_start", nxt_s, 0);
      wait_rx(1, 2, "rx_b_two");
      drain(1, 2);
      loop_b = 1'b0;

      // injected parity and stop errors on the 7E2 receiver
      bang(1, frame_b(7'h2A, 1'b1, 1'b1), 11);
      q_b.push_back({2'b10, 1'b0, 7'h2A});
      bang(1, frame_b(7'h13, 1'b0, 1'b1), 11);
      q_b.push_back({2'b00, 1'b0, 7'h13});
      bang(1, frame_b(7'h61, 1'b0, 1'b0), 11);
      q_b.push_back({2'b01, 1'b0, 7'h61});
      wait_rx(1, 3, "rx_b_inject");
      drain(1, 3);

      // overrun: DEPTH+1 frames with rx_ready held low
      loop_a = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         logic [7:0] d;
         d = 8'((i + 1) * 17);
         bang(0, frame_a(d, 1'b1), 10);
         if (i < DEPTH) q_a.push_back({2'b00, d});
      end
      chk("ovr_count", rx_cnt_a, DEPTH);
      chk("ovr_flag", ovr_a, 1);
      drain(0, DEPTH);
      chk("ovr_sticky", ovr_a, 1);
      err_clr_a = 1'b1;
      @(negedge clk);
      err_clr_a = 1'b0;
      chk("ovr_cleared", ovr_a, 0);

      // short low glitch, then a real frame
      drv_a = 1'b0;
      repeat (16) @(negedge clk);
      drv_a = 1'b1;
      repeat (200) @(negedge clk);
      chk("glitch_no_push", {rx_valid_a, rx_cnt_a}, 0);
      bang(0, frame_a(8'hC3, 1'b1), 10);
      q_a.push_back({2'b00, 8'hC3});
      wait_rx(0, 1, "rx_after_glitch");
      drain(0, 1);

      // TX stalled by the largest divisor: only DEPTH writes accepted
      baud_a = 16'hFFFF;
      repeat (2) @(negedge clk);
      acc = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         tx_valid_a = 1'b1; tx_data_a = 8'(i);
         if (tx_ready_a) acc++;
         @(negedge clk);
      end
      tx_valid_a = 1'b0;
      chk("stall_accepts", acc, DEPTH);
      chk("stall_ready", tx_ready_a, 0);
      chk("stall_count", tx_cnt_a, DEPTH);

      // reset in the middle of a frame
      loop_a = 1'b1;
      baud_a = 16'd3;
      t = 0;
      while (!busy_a && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (100) @(negedge clk);
      chk("mid_busy", busy_a, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_txd", txd_a, 1);
      chk("mid_rst_tx_count", tx_cnt_a, 0);
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_rx_count", rx_cnt_a, 0);
      rst = 1'b0;
      @(negedge clk);
      tx_valid_a = 1'b1; tx_data_a = 8'h5A;
      q_a.push_back({2'b00, 8'h5A});
      @(negedge clk);
      tx_valid_a = 1'b0;
      wait_rx(0, 1, "rx_after_rst");
      drain(0, 1);
      chk("end_rx_valid", rx_valid_a, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
